// File: rtl/ula_serial_n_bits_if.sv
`default_nettype none
// ============================================================================
// Module   : ula_serial_n_bits_if
// Brief    : Operand/result valid-ready bundle for the slice-serial ALU.
// Revision : 1.0
// ============================================================================
interface ula_serial_n_bits_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             overflow;
  logic             a_eq_b;
  logic             zero;
  logic             illegal_op;

  modport master (
    output in_valid, a, b, s, m, c_in, out_ready,
    input  in_ready, out_valid, f, c_out, overflow, a_eq_b, zero, illegal_op
  );

  modport slave (
    input  in_valid, a, b, s, m, c_in, out_ready,
    output in_ready, out_valid, f, c_out, overflow, a_eq_b, zero, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/ula_serial_n_bits.sv
`default_nettype none
// ============================================================================
// Module   : ula_serial_n_bits
// Brief    : WIDTH-bit ALU computed SLICE bits per clock, LSB slice first.
// Revision : 1.0
// ============================================================================
module ula_serial_n_bits #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input wire                clk,
  input wire                rst_n,
  ula_serial_n_bits_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             eq_q, eq_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  logic             in_ready, out_valid;
  logic             legal, last, cin_msb;
  logic [SLICE-1:0] a_sl, b_sl, b_op, logic_res, res_sl;
  logic [SLICE:0]   sum;

  // Slice datapath, driven by the registered operation code
  always_comb begin : p_slice
    a_sl  = a_q[int'(idx_q)*SLICE +: SLICE];
    b_sl  = b_q[int'(idx_q)*SLICE +: SLICE];
    last  = (idx_q == LAST_IDX);
    legal = m_q ? ~s_q[3]
                : (s_q == 4'b0000) || (s_q == 4'b0101) ||
                  (s_q == 4'b1000) || (s_q == 4'b1111);
    b_op = '0;
    case (s_q)
      4'b0101: b_op = b_sl;
      4'b1000: b_op = ~b_sl;
      4'b1111: b_op = '1;
      default: b_op = '0;
    endcase
    sum = {1'b0, a_sl} + {1'b0, b_op} + {{SLICE{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from its sum bit
    cin_msb = sum[SLICE-1] ^ a_sl[SLICE-1] ^ b_op[SLICE-1];
    logic_res = '0;
    case (s_q[2:0])
      3'd0:    logic_res = ~a_sl;
      3'd1:    logic_res = a_sl & b_sl;
      3'd2:    logic_res = a_sl | b_sl;
      3'd3:    logic_res = a_sl ^ b_sl;
      3'd4:    logic_res = ~(a_sl & b_sl);
      3'd5:    logic_res = ~(a_sl | b_sl);
      3'd6:    logic_res = ~(a_sl ^ b_sl);
      default: logic_res = b_sl;
    endcase
    if (!legal)   res_sl = '0;
    else if (m_q) res_sl = logic_res;
    else          res_sl = sum[SLICE-1:0];
  end

  always_comb begin : p_next
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    m_d       = m_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    f_d       = f_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    eq_d      = eq_q;
    zero_d    = zero_q;
    ill_d     = ill_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          s_d     = bus.s;
          m_d     = bus.m;
          carry_d = bus.c_in;
          idx_d   = '0;
          eq_d    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        f_d[int'(idx_q)*SLICE +: SLICE] = res_sl;
        carry_d = sum[SLICE];
        eq_d    = eq_q & (a_sl == b_sl);
        if (last) begin
          c_out_d = legal & ~m_q & sum[SLICE];
          ovf_d   = legal & ~m_q & (cin_msb ^ sum[SLICE]);
          zero_d  = (f_d == '0);
          ill_d   = ~legal;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : p_regs
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      f_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      eq_q    <= 1'b0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      f_q     <= f_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      eq_q    <= eq_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.f          = f_q;
  assign bus.c_out      = c_out_q;
  assign bus.overflow   = ovf_q;
  assign bus.a_eq_b     = eq_q;
  assign bus.zero       = zero_q;
  assign bus.illegal_op = ill_q;
endmodule
`default_nettype wire

// File: tb/tb_ula_serial_n_bits.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_serial_n_bits
// Brief    : Self-checking bench for the slice-serial ALU (8/16/4-bit builds).
// Revision : 1.0
// ============================================================================
module tb_ula_serial_n_bits;
  logic clk = 1'b0;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  ula_serial_n_bits_if #(.WIDTH(8))  bus8 ();
  ula_serial_n_bits_if #(.WIDTH(16)) bus16 ();
  ula_serial_n_bits_if #(.WIDTH(4))  bus4 ();

  ula_serial_n_bits #(.WIDTH(8), .SLICE(4))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  ula_serial_n_bits #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  ula_serial_n_bits #(.WIDTH(4), .SLICE(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  // Reference: {f, c_out, overflow, a_eq_b, zero, illegal_op} for an 8-bit op
  function automatic logic [12:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s, input logic m, input logic cin);
    logic [7:0] f, bop;
    logic [8:0] full;
    logic       c, ov, il;
    f = 8'd0; bop = 8'd0; c = 1'b0; ov = 1'b0; il = 1'b0; full = 9'd0;
    if (m) begin
      case (s)
        4'd0: f = ~a;
        4'd1: f = a & b;
        4'd2: f = a | b;
        4'd3: f = a ^ b;
        4'd4: f = ~(a & b);
        4'd5: f = ~(a | b);
        4'd6: f = ~(a ^ b);
        4'd7: f = b;
        default: il = 1'b1;
      endcase
    end else begin
      case (s)
        4'd0:  bop = 8'h00;
        4'd5:  bop = b;
        4'd8:  bop = ~b;
        4'd15: bop = 8'hFF;
        default: il = 1'b1;
      endcase
      if (!il) begin
        full = {1'b0, a} + {1'b0, bop} + {8'd0, cin};
        f    = full[7:0];
        c    = full[8];
        ov   = (a[7] == bop[7]) && (f[7] != a[7]);
      end
    end
    return {f, c, ov, (a == b), (f == 8'd0), il};
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                      input logic m, input logic cin, output int lat, output logic [12:0] got);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.s = s; bus8.m = m; bus8.c_in = cin;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    @(posedge clk); #1 bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    got = {bus8.f, bus8.c_out, bus8.overflow, bus8.a_eq_b, bus8.zero, bus8.illegal_op};
    bus8.out_ready = 1'b1;
    @(posedge clk); #1 bus8.out_ready = 1'b0;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                       input logic m, input logic cin, output int lat, output logic [20:0] got);
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.s = s; bus16.m = m; bus16.c_in = cin;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b0;
    @(posedge clk); #1 bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    got = {bus16.f, bus16.c_out, bus16.overflow, bus16.a_eq_b, bus16.zero, bus16.illegal_op};
    bus16.out_ready = 1'b1;
    @(posedge clk); #1 bus16.out_ready = 1'b0;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                      input logic m, input logic cin, output int lat, output logic [8:0] got);
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.s = s; bus4.m = m; bus4.c_in = cin;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    @(posedge clk); #1 bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    got = {bus4.f, bus4.c_out, bus4.overflow, bus4.a_eq_b, bus4.zero, bus4.illegal_op};
    bus4.out_ready = 1'b1;
    @(posedge clk); #1 bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.in_valid = 0;  bus8.out_ready = 0;  bus8.a = 0;  bus8.b = 0;  bus8.s = 0;  bus8.m = 0;  bus8.c_in = 0;
    bus16.in_valid = 0; bus16.out_ready = 0; bus16.a = 0; bus16.b = 0; bus16.s = 0; bus16.m = 0; bus16.c_in = 0;
    bus4.in_valid = 0;  bus4.out_ready = 0;  bus4.a = 0;  bus4.b = 0;  bus4.s = 0;  bus4.m = 0;  bus4.c_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({bus8.in_ready, bus8.out_valid, bus8.f, bus8.c_out, bus8.overflow, bus8.a_eq_b,
         bus8.zero, bus8.illegal_op} !== {1'b1, 1'b0, 8'h00, 5'b0}) begin
      mismatched++;
      $display("FAIL reset8 got rdy=%b vld=%b f=%h flags=%b%b%b%b%b exp rdy=1 vld=0 f=00 flags=00000",
               bus8.in_ready, bus8.out_valid, bus8.f, bus8.c_out, bus8.overflow,
               bus8.a_eq_b, bus8.zero, bus8.illegal_op);
    end
    compared++;
    if ({bus16.in_ready, bus16.out_valid, bus4.in_ready, bus4.out_valid} !== 4'b1010) begin
      mismatched++;
      $display("FAIL reset_sweep got %b%b%b%b exp 1010", bus16.in_ready, bus16.out_valid,
               bus4.in_ready, bus4.out_valid);
    end
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  s;
    logic        m;
    logic        cin;
    logic [12:0] exp;
  } vec8_t;

  // Directed vectors with hand-derived results: {f, c, ov, eq, zero, illegal}
  task automatic test_directed();
    vec8_t       v [8];
    int          lat;
    logic [12:0] got;
    v[0] = '{8'h7F, 8'h01, 4'b0101, 1'b0, 1'b0, {8'h80, 5'b01000}};
    v[1] = '{8'hFF, 8'h01, 4'b0101, 1'b0, 1'b0, {8'h00, 5'b10010}};
    v[2] = '{8'h0A, 8'h05, 4'b1000, 1'b0, 1'b1, {8'h05, 5'b10000}};
    v[3] = '{8'h05, 8'h0A, 4'b1000, 1'b0, 1'b1, {8'hFB, 5'b00000}};
    v[4] = '{8'h80, 8'h01, 4'b1000, 1'b0, 1'b1, {8'h7F, 5'b11000}};
    v[5] = '{8'h55, 8'h55, 4'b0011, 1'b1, 1'b0, {8'h00, 5'b00110}};
    v[6] = '{8'h55, 8'hD5, 4'b0011, 1'b1, 1'b0, {8'h80, 5'b00000}};
    v[7] = '{8'h12, 8'h34, 4'b1010, 1'b1, 1'b0, {8'h00, 5'b00011}};
    for (int i = 0; i < 8; i++) begin
      run8(v[i].a, v[i].b, v[i].s, v[i].m, v[i].cin, lat, got);
      compared++;
      if (got !== v[i].exp) begin
        mismatched++;
        $display("FAIL directed[%0d] got {f,c,ov,eq,z,il}=%h/%b exp %h/%b", i,
                 got[12:5], got[4:0], v[i].exp[12:5], v[i].exp[4:0]);
      end
      compared++;
      if (lat !== 2) begin
        mismatched++;
        $display("FAIL latency8[%0d] got %0d exp 2", i, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic [3:0]  s;
    logic        m, cin;
    logic [12:0] got, exp;
    int          lat;
    logic [3:0]  arith_codes [4];
    arith_codes[0] = 4'b0000; arith_codes[1] = 4'b0101;
    arith_codes[2] = 4'b1000; arith_codes[3] = 4'b1111;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom); cin = 1'($urandom);
      if ($urandom_range(0, 3) == 0) b = a;
      if (!m && $urandom_range(0, 3) != 0) s = arith_codes[$urandom_range(0, 3)];
      else s = 4'($urandom);
      exp = model8(a, b, s, m, cin);
      run8(a, b, s, m, cin, lat, got);
      compared++;
      if (got !== exp || lat !== 2) begin
        mismatched++;
        $display("FAIL random[%0d] a=%h b=%h m=%b s=%b cin=%b got %h/%b lat=%0d exp %h/%b lat=2",
                 i, a, b, m, s, cin, got[12:5], got[4:0], lat, exp[12:5], exp[4:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] exp, now;
    int          lat;
    exp = model8(8'h3C, 8'h0F, 4'b0101, 1'b0, 1'b1);
    @(negedge clk);
    bus8.a = 8'h3C; bus8.b = 8'h0F; bus8.s = 4'b0101; bus8.m = 1'b0; bus8.c_in = 1'b1;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    @(posedge clk); #1 bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    // Offer a competing op while the result is held
    bus8.a = 8'hAA; bus8.b = 8'h11; bus8.s = 4'b0011; bus8.m = 1'b1; bus8.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      now = {bus8.f, bus8.c_out, bus8.overflow, bus8.a_eq_b, bus8.zero, bus8.illegal_op};
      compared++;
      if ({bus8.out_valid, bus8.in_ready, now} !== {1'b1, 1'b0, exp}) begin
        mismatched++;
        $display("FAIL backpressure_hold[%0d] got vld=%b rdy=%b res=%h exp vld=1 rdy=0 res=%h",
                 k, bus8.out_valid, bus8.in_ready, now, exp);
      end
    end
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    @(posedge clk); #1 bus8.out_ready = 1'b0;
    compared++;
    if ({bus8.in_ready, bus8.out_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL backpressure_release got rdy=%b vld=%b exp rdy=1 vld=0",
               bus8.in_ready, bus8.out_valid);
    end
    repeat (3) @(negedge clk);
    compared++;
    if ({bus8.in_ready, bus8.out_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL backpressure_ignored got rdy=%b vld=%b exp rdy=1 vld=0",
               bus8.in_ready, bus8.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] got, exp;
    int          lat;
    @(negedge clk);
    bus8.a = 8'h7F; bus8.b = 8'h01; bus8.s = 4'b0101; bus8.m = 1'b0; bus8.c_in = 1'b0;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    @(posedge clk); #1 bus8.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    compared++;
    if ({bus8.in_ready, bus8.out_valid, bus8.f, bus8.c_out, bus8.overflow, bus8.a_eq_b,
         bus8.zero, bus8.illegal_op} !== {1'b1, 1'b0, 8'h00, 5'b0}) begin
      mismatched++;
      $display("FAIL reset_mid got rdy=%b vld=%b f=%h exp rdy=1 vld=0 f=00 flags=0",
               bus8.in_ready, bus8.out_valid, bus8.f);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if (bus8.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_discard got vld=%b exp 0", bus8.out_valid);
    end
    exp = model8(8'hC3, 8'h3C, 4'b1111, 1'b0, 1'b0);
    run8(8'hC3, 8'h3C, 4'b1111, 1'b0, 1'b0, lat, got);
    compared++;
    if (got !== exp || lat !== 2) begin
      mismatched++;
      $display("FAIL reset_mid_next got %h lat=%0d exp %h lat=2", got, lat, exp);
    end
  endtask

  task automatic test_sweep();
    logic [20:0] got16;
    logic [8:0]  got4;
    int          lat;
    run16(16'h7FFF, 16'h0001, 4'b0101, 1'b0, 1'b0, lat, got16);
    compared++;
    if (got16 !== {16'h8000, 5'b01000} || lat !== 4) begin
      mismatched++;
      $display("FAIL sweep16_add got %h/%b lat=%0d exp 8000/01000 lat=4", got16[20:5], got16[4:0], lat);
    end
    run16(16'h0000, 16'h0001, 4'b1000, 1'b0, 1'b1, lat, got16);
    compared++;
    if (got16 !== {16'hFFFF, 5'b00000} || lat !== 4) begin
      mismatched++;
      $display("FAIL sweep16_sub got %h/%b lat=%0d exp FFFF/00000 lat=4", got16[20:5], got16[4:0], lat);
    end
    run16(16'hA5A5, 16'hA5A5, 4'b0110, 1'b1, 1'b0, lat, got16);
    compared++;
    if (got16 !== {16'hFFFF, 5'b00100}) begin
      mismatched++;
      $display("FAIL sweep16_xnor got %h/%b exp FFFF/00100", got16[20:5], got16[4:0]);
    end
    run4(4'hF, 4'h1, 4'b0101, 1'b0, 1'b0, lat, got4);
    compared++;
    if (got4 !== {4'h0, 5'b10010} || lat !== 1) begin
      mismatched++;
      $display("FAIL sweep4_add got %h/%b lat=%0d exp 0/10010 lat=1", got4[8:5], got4[4:0], lat);
    end
    run4(4'h7, 4'h1, 4'b0101, 1'b0, 1'b0, lat, got4);
    compared++;
    if (got4 !== {4'h8, 5'b01000} || lat !== 1) begin
      mismatched++;
      $display("FAIL sweep4_ovf got %h/%b lat=%0d exp 8/01000 lat=1", got4[8:5], got4[4:0], lat);
    end
    run4(4'h5, 4'h9, 4'b0000, 1'b1, 1'b0, lat, got4);
    compared++;
    if (got4 !== {4'hA, 5'b00000}) begin
      mismatched++;
      $display("FAIL sweep4_not got %h/%b exp A/00000", got4[8:5], got4[4:0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
